lut_layer_sequencer: RTL and testbench

Time-multiplexed evaluator for one LogicNets-style quantized layer. Each neuron is a truth table indexed by FAN_IN activations of IN_BITS each. Instead of one ROM per neuron, the block holds every neuron's table and connectivity in two internal RAMs and evaluates one neuron per cycle through a 3-stage pipeline. It accepts a full input activation vector, produces the full output vector, and exposes a write port so tables and connectivity can be loaded at run time.

---
 rtl/lut_layer_pkg.sv | 33 +++
 rtl/lut_layer_ram.sv | 42 ++++
 rtl/lut_layer_sequencer.sv | 168 ++++++++++++++++
 tb/tb_lut_layer_sequencer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/lut_layer_pkg.sv
// Shared types, default sizing and width helpers for the LUT layer sequencer.
package lut_layer_pkg;

  localparam int unsigned DEF_NUM_IN      = 128;
  localparam int unsigned DEF_IN_BITS     = 2;
  localparam int unsigned DEF_FAN_IN      = 4;
  localparam int unsigned DEF_NUM_NEURONS = 128;
  localparam int unsigned DEF_OUT_BITS    = 2;

  // Index width for a set of n items; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Derived widths for the default layer size.
  localparam int unsigned TA       = DEF_FAN_IN * DEF_IN_BITS;
  localparam int unsigned NEURON_W = idx_w(DEF_NUM_NEURONS);
  localparam int unsigned SRC_W    = idx_w(DEF_NUM_IN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic CFG_SEL_TABLE = 1'b0;
  localparam logic CFG_SEL_CONN  = 1'b1;

endpackage

// File: rtl/lut_layer_ram.sv
// Synchronous-read RAM with one write port and optional per-lane write enables.
module lut_layer_ram
  import lut_layer_pkg::*;
#(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LANES = 1,
  parameter bit          BLOCK = 1'b1,
  localparam int unsigned AW   = idx_w(DEPTH),
  localparam int unsigned LW   = WIDTH / LANES
) (
  input  logic             clk,
  input  logic [LANES-1:0] we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  if (BLOCK) begin : g_block
    (* ram_style = "block" *) logic [WIDTH-1:0] mem [DEPTH];

    // Lane-masked write and registered read.
    always_ff @(posedge clk) begin
      for (int unsigned l = 0; l < LANES; l++) begin
        if (we[l]) mem[waddr][l*LW +: LW] <= wdata[l*LW +: LW];
      end
      rdata <= mem[raddr];
    end
  end else begin : g_dist
    (* ram_style = "distributed" *) logic [WIDTH-1:0] mem [DEPTH];

    // Lane-masked write and registered read.
    always_ff @(posedge clk) begin
      for (int unsigned l = 0; l < LANES; l++) begin
        if (we[l]) mem[waddr][l*LW +: LW] <= wdata[l*LW +: LW];
      end
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/lut_layer_sequencer.sv
// Evaluates one quantized LUT layer, one neuron per cycle, from RAM-held
// connectivity and truth tables loaded through a config write port.
module lut_layer_sequencer
  import lut_layer_pkg::*;
#(
  parameter int unsigned NUM_IN      = DEF_NUM_IN,
  parameter int unsigned IN_BITS     = DEF_IN_BITS,
  parameter int unsigned FAN_IN      = DEF_FAN_IN,
  parameter int unsigned NUM_NEURONS = DEF_NUM_NEURONS,
  parameter int unsigned OUT_BITS    = DEF_OUT_BITS,
  localparam int unsigned TAW = FAN_IN * IN_BITS,
  localparam int unsigned NW  = idx_w(NUM_NEURONS),
  localparam int unsigned SW  = idx_w(NUM_IN),
  localparam int unsigned SLW = idx_w(FAN_IN),
  localparam int unsigned WD  = max_u(OUT_BITS, SW)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            cfg_we,
  input  logic                            cfg_sel,
  input  logic [NW+TAW-1:0]               cfg_addr,
  input  logic [WD-1:0]                   cfg_wdata,
  output logic                            cfg_err,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [NUM_IN*IN_BITS-1:0]       in_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NUM_NEURONS*OUT_BITS-1:0] out_data,
  output logic                            busy
);

  localparam int unsigned NACT = 2**SW;
  localparam logic [NW-1:0] LAST = NW'(NUM_NEURONS - 1);

  state_t                    state;
  logic [NW-1:0]             cnt;
  logic                      run;
  logic                      rdy_q;
  logic                      err_q;
  logic                      s1_v, s2_v;
  logic [NW-1:0]             s1_n, s2_n;
  logic [IN_BITS-1:0]        act_q   [NACT];
  logic [OUT_BITS-1:0]       out_arr [NUM_NEURONS];

  logic                      cfg_ok;
  logic                      accept;
  logic [FAN_IN-1:0]         conn_we;
  logic [FAN_IN*SW-1:0]      conn_rdata;
  logic [TAW-1:0]            tbl_idx;
  logic [OUT_BITS-1:0]       tbl_rdata;

  assign cfg_ok    = cfg_we && (state == IDLE) && !in_valid;
  assign in_ready  = rdy_q && !cfg_we;
  assign accept    = in_valid && in_ready;
  assign cfg_err   = err_q;
  assign busy      = (state == EVAL);
  assign out_valid = (state == DONE);

  // Connectivity writes touch only the addressed slot of a neuron's word.
  always_comb begin
    conn_we = '0;
    if (cfg_ok && cfg_sel == CFG_SEL_CONN) conn_we[cfg_addr[SLW-1:0]] = 1'b1;
  end

  lut_layer_ram #(
    .DEPTH (2**NW),
    .WIDTH (FAN_IN * SW),
    .LANES (FAN_IN),
    .BLOCK (1'b0)
  ) u_conn (
    .clk   (clk),
    .we    (conn_we),
    .waddr (cfg_addr[SLW +: NW]),
    .wdata ({FAN_IN{cfg_wdata[SW-1:0]}}),
    .raddr (cnt),
    .rdata (conn_rdata)
  );

  // Gather source activations into the table index, slot 0 in the LSBs.
  // act_q is padded to 2**SW entries so out-of-range sources read as zero.
  always_comb begin
    tbl_idx = '0;
    for (int unsigned s = 0; s < FAN_IN; s++) begin
      tbl_idx[s*IN_BITS +: IN_BITS] = act_q[conn_rdata[s*SW +: SW]];
    end
  end

  lut_layer_ram #(
    .DEPTH (2**(NW + TAW)),
    .WIDTH (OUT_BITS),
    .LANES (1),
    .BLOCK (1'b1)
  ) u_table (
    .clk   (clk),
    .we    (cfg_ok && cfg_sel == CFG_SEL_TABLE),
    .waddr (cfg_addr),
    .wdata (cfg_wdata[OUT_BITS-1:0]),
    .raddr ({s1_n, tbl_idx}),
    .rdata (tbl_rdata)
  );

  // Latch the input vector on accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int unsigned k = 0; k < NACT; k++) begin
        act_q[k] <= (k < NUM_IN) ? in_data[k*IN_BITS +: IN_BITS] : '0;
      end
    end
  end

  // Control FSM, neuron counter, pipeline valids and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      run   <= 1'b0;
      rdy_q <= 1'b0;
      err_q <= 1'b0;
      s1_v  <= 1'b0;
      s2_v  <= 1'b0;
      s1_n  <= '0;
      s2_n  <= '0;
      for (int unsigned n = 0; n < NUM_NEURONS; n++) out_arr[n] <= '0;
    end else begin
      err_q <= cfg_we && !cfg_ok;
      s1_v  <= run;
      s1_n  <= cnt;
      s2_v  <= s1_v;
      s2_n  <= s1_n;
      if (s2_v) out_arr[s2_n] <= tbl_rdata;
      case (state)
        IDLE: begin
          rdy_q <= 1'b1;
          if (accept) begin
            state <= EVAL;
            rdy_q <= 1'b0;
            cnt   <= '0;
            run   <= 1'b1;
          end
        end
        EVAL: begin
          if (run) begin
            if (cnt == LAST) run <= 1'b0;
            else             cnt <= cnt + 1'b1;
          end
          if (s2_v && s2_n == LAST) state <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
            rdy_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Flatten the neuron results onto the output bus.
  always_comb begin
    out_data = '0;
    for (int unsigned n = 0; n < NUM_NEURONS; n++) begin
      out_data[n*OUT_BITS +: OUT_BITS] = out_arr[n];
    end
  end

endmodule

// File: tb/tb_lut_layer_sequencer.sv
// Directed self-checking bench for lut_layer_sequencer (default sizing).
module tb_lut_layer_sequencer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cfg_we;
  logic         cfg_sel;
  logic [14:0]  cfg_addr;
  logic [6:0]   cfg_wdata;
  logic         cfg_err;
  logic         in_valid;
  logic         in_ready;
  logic [255:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [255:0] out_data;
  logic         busy;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int t_acc  = 0;

  logic [255:0] all01;
  logic [255:0] vec;
  logic [255:0] exp_v;

  lut_layer_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_sel   (cfg_sel),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_err   (cfg_err),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input string tag, input logic [255:0] v);
    in_data  = v;
    in_valid = 1'b1;
    #1;
    chk({tag, "_in_ready"}, 256'(in_ready), 256'd1);
    step();
    in_valid = 1'b0;
    t_acc    = cyc;
  endtask

  task automatic wait_done(input string tag, input logic [255:0] exp, input int hold);
    while (!out_valid && (cyc - t_acc) < 400) step();
    chk({tag, "_latency"}, 256'(cyc - t_acc), 256'd130);
    chk({tag, "_data"}, out_data, exp);
    for (int h = 0; h < hold; h++) begin
      step();
      chk({tag, "_hold_valid"}, 256'(out_valid), 256'd1);
      chk({tag, "_hold_data"}, out_data, exp);
      chk({tag, "_hold_ready"}, 256'(in_ready), 256'd0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_post_valid"}, 256'(out_valid), 256'd0);
    chk({tag, "_post_ready"}, 256'(in_ready), 256'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    cfg_we    = 1'b0;
    cfg_sel   = 1'b0;
    cfg_addr  = '0;
    cfg_wdata = '0;
    in_valid  = 1'b1;
    in_data   = '0;
    out_ready = 1'b0;
    for (int n = 0; n < 128; n++) all01[n*2 +: 2] = 2'b01;

    // Reset held with in_valid asserted.
    repeat (3) step();
    chk("rst_in_ready", 256'(in_ready), 256'd0);
    chk("rst_out_valid", 256'(out_valid), 256'd0);
    chk("rst_busy", 256'(busy), 256'd0);
    chk("rst_out_data", out_data, '0);
    chk("rst_cfg_err", 256'(cfg_err), 256'd0);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    #1;
    chk("rel_in_ready_low", 256'(in_ready), 256'd0);
    step();
    chk("rel_in_ready_high", 256'(in_ready), 256'd1);

    // Load tables: index 0 -> 01, everything else 00; connectivity {0,1,2,3}.
    cfg_we  = 1'b1;
    cfg_sel = 1'b0;
    for (int n = 0; n < 128; n++) begin
      for (int i = 0; i < 256; i++) begin
        cfg_addr  = 15'(n * 256 + i);
        cfg_wdata = (i == 0) ? 7'd1 : 7'd0;
        step();
      end
    end
    cfg_sel = 1'b1;
    for (int n = 0; n < 128; n++) begin
      for (int s = 0; s < 4; s++) begin
        cfg_addr  = 15'(n * 4 + s);
        cfg_wdata = 7'(s);
        step();
      end
    end
    cfg_we = 1'b0;
    chk("load_cfg_err", 256'(cfg_err), 256'd0);
    step();

    // All-zero input, with 20 cycles of output backpressure.
    send("zero", '0);
    chk("zero_busy", 256'(busy), 256'd1);
    wait_done("zero", all01, 20);

    // Activation 0 = 1 moves every neuron off table index 0.
    vec = '0;
    vec[1:0] = 2'b01;
    send("act0", vec);
    wait_done("act0", '0, 0);

    // Config write during EVAL is rejected.
    send("rej_eval", '0);
    repeat (10) step();
    cfg_we    = 1'b1;
    cfg_sel   = 1'b0;
    cfg_addr  = {7'd3, 8'd0};
    cfg_wdata = 7'd0;
    step();
    cfg_we = 1'b0;
    chk("rej_eval_err", 256'(cfg_err), 256'd1);
    step();
    chk("rej_eval_err_pulse", 256'(cfg_err), 256'd0);
    wait_done("rej_eval", all01, 0);

    // Config write in IDLE with in_valid high is rejected and blocks accept.
    in_valid  = 1'b1;
    in_data   = '0;
    cfg_we    = 1'b1;
    cfg_sel   = 1'b0;
    cfg_addr  = {7'd3, 8'd0};
    cfg_wdata = 7'd0;
    #1;
    chk("rej_idle_in_ready", 256'(in_ready), 256'd0);
    step();
    cfg_we   = 1'b0;
    in_valid = 1'b0;
    chk("rej_idle_err", 256'(cfg_err), 256'd1);
    chk("rej_idle_busy", 256'(busy), 256'd0);
    step();
    send("rerun", '0);
    wait_done("rerun", all01, 0);

    // Reset while neuron 50 is being written.
    send("abort", '0);
    while ((cyc - t_acc) < 53) step();
    rst_n = 1'b0;
    #1;
    chk("abort_out_data", out_data, '0);
    chk("abort_busy", 256'(busy), 256'd0);
    chk("abort_out_valid", 256'(out_valid), 256'd0);
    chk("abort_in_ready", 256'(in_ready), 256'd0);
    step();
    rst_n = 1'b1;
    step();
    send("resend", '0);
    wait_done("resend", all01, 0);

    // Slot ordering: neuron 5 reads activation 9 through slot 0.
    cfg_we    = 1'b1;
    cfg_sel   = 1'b0;
    cfg_wdata = 7'd0;
    for (int n = 0; n < 128; n++) begin
      cfg_addr = 15'(n * 256);
      step();
    end
    cfg_addr  = {7'd5, 8'h03};
    cfg_wdata = 7'd2;
    step();
    cfg_sel = 1'b1;
    for (int s = 0; s < 4; s++) begin
      cfg_addr  = 15'(5 * 4 + s);
      cfg_wdata = (s == 0) ? 7'd9 : 7'd0;
      step();
    end
    cfg_we = 1'b0;
    step();
    vec = '0;
    vec[19:18] = 2'b11;
    exp_v = '0;
    exp_v[11:10] = 2'b10;
    send("slot", vec);
    wait_done("slot", exp_v, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
